opsel_pipe: RTL and testbench

- Parametrised, registered operand selector for the GF(2^m) inversion datapath.
- Picks two multiplicands (A and B) independently from NUM_IN candidate buffers.
- Results are held in a small FIFO and handed to the multiplier through a valid/ready handshake.
- Generalises the plain 4:1 multiplicand mux in width, input count and buffering, and adds an out-of-range select error.

---
 rtl/opsel_pipe.sv | 135 +++++++++++++
 tb/tb_opsel_pipe.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/opsel_pipe.sv
// opsel_pipe: registered operand selector for the GF(2^m) inversion datapath.
// Picks multiplicands A and B from NUM_IN flattened candidates, flags
// out-of-range selects, and queues results in a DEPTH-entry FIFO that is
// drained through a valid/ready handshake.
// Optional build macro OPSEL_BYPASS_EN: an empty FIFO presents the incoming
// selection on the outputs in the same cycle (zero-latency pass-through).
module opsel_pipe #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  parameter  int DEPTH  = 2,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]        sel_a,
  input  logic [SEL_W-1:0]        sel_b,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_a,
  output logic [WIDTH-1:0]        out_b,
  output logic                    sel_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);
  localparam logic [SEL_W:0]   NUM_C   = (SEL_W + 1)'(NUM_IN);

  logic [WIDTH-1:0] mem_a_q [DEPTH];
  logic [WIDTH-1:0] mem_a_d [DEPTH];
  logic [WIDTH-1:0] mem_b_q [DEPTH];
  logic [WIDTH-1:0] mem_b_d [DEPTH];
  logic             err_q   [DEPTH];
  logic             err_d   [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;

  logic [WIDTH-1:0] a_sel, b_sel;
  logic             err_sel;
  logic             push, pop, wr;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  // Candidate mux; an out-of-range select matches no candidate and yields 0.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel_a == SEL_W'(k)) a_sel = din[k*WIDTH +: WIDTH];
      if (sel_b == SEL_W'(k)) b_sel = din[k*WIDTH +: WIDTH];
    end
    err_sel = ({1'b0, sel_a} >= NUM_C) | ({1'b0, sel_b} >= NUM_C);
  end

  // Handshake flags and head-entry outputs.
  always_comb begin
    in_ready = (cnt_q != FULL_C);
    push     = in_valid & in_ready;
`ifdef OPSEL_BYPASS_EN
    out_valid = (cnt_q != '0) | in_valid;
    pop       = (cnt_q != '0) & out_ready;
    if (cnt_q == '0) begin
      out_a   = a_sel;
      out_b   = b_sel;
      sel_err = err_sel;
      // Consumed on the spot: nothing is stored.
      wr      = push & ~out_ready;
    end else begin
      out_a   = mem_a_q[rptr_q];
      out_b   = mem_b_q[rptr_q];
      sel_err = err_q[rptr_q];
      wr      = push;
    end
`else
    out_valid = (cnt_q != '0);
    pop       = out_valid & out_ready;
    wr        = push;
    out_a     = mem_a_q[rptr_q];
    out_b     = mem_b_q[rptr_q];
    sel_err   = err_q[rptr_q];
`endif
  end

  // Next-state for FIFO storage, pointers and occupancy count.
  always_comb begin
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    err_d   = err_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    cnt_d   = cnt_q;
    if (wr) begin
      mem_a_d[wptr_q] = a_sel;
      mem_b_d[wptr_q] = b_sel;
      err_d[wptr_q]   = err_sel;
      wptr_d          = ptr_inc(wptr_q);
    end
    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    case ({wr, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; asynchronous reset empties the FIFO and clears storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_a_q <= '{default: '0};
      mem_b_q <= '{default: '0};
      err_q   <= '{default: 1'b0};
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
      err_q   <= err_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_opsel_pipe.sv
// Directed scoreboard bench for opsel_pipe (WIDTH 8, NUM_IN 5, DEPTH 2).
module tb_opsel_pipe;

  localparam int WIDTH  = 8;
  localparam int NUM_IN = 5;
  localparam int DEPTH  = 2;
  localparam int SEL_W  = 3;
`ifdef OPSEL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err;
  } exp_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] din;
  logic [SEL_W-1:0]        sel_a, sel_b;
  logic                    in_valid, in_ready;
  logic [WIDTH-1:0]        out_a, out_b;
  logic                    sel_err, out_valid, out_ready;

  logic [WIDTH-1:0] cand [NUM_IN];
  exp_t             sb [$];
  int               tests = 0;
  int               fails = 0;

  opsel_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .sel_a(sel_a), .sel_b(sel_b),
    .in_valid(in_valid), .in_ready(in_ready), .out_a(out_a), .out_b(out_b),
    .sel_err(sel_err), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [SEL_W-1:0] sa, input logic [SEL_W-1:0] sbs);
    exp_t e;
    e.a   = (int'(sa)  < NUM_IN) ? cand[sa]  : '0;
    e.b   = (int'(sbs) < NUM_IN) ? cand[sbs] : '0;
    e.err = (int'(sa) >= NUM_IN) || (int'(sbs) >= NUM_IN);
    return e;
  endfunction

  task automatic drive(input logic v, input int sa, input int sbs, input logic rdy);
    for (int k = 0; k < NUM_IN; k++) din[k*WIDTH +: WIDTH] = cand[k];
    in_valid  = v;
    sel_a     = SEL_W'(sa);
    sel_b     = SEL_W'(sbs);
    out_ready = rdy;
  endtask

  // One clock: check handshake against the model, update the scoreboard,
  // compare the head entry, then advance to the next falling edge.
  task automatic tick(input string tag);
    int   prior;
    bit   push, exp_ov;
    exp_t e;
    #1;
    prior = sb.size();
    push  = in_valid && (prior < DEPTH);
    check({tag, ".in_ready"}, 32'(in_ready), 32'(prior != DEPTH));
    if (push) sb.push_back(model(sel_a, sel_b));
    exp_ov = BYP ? (sb.size() != 0) : (prior != 0);
    check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_ov));
    if (exp_ov) begin
      e = sb[0];
      check({tag, ".out_a"},   32'(out_a),   32'(e.a));
      check({tag, ".out_b"},   32'(out_b),   32'(e.b));
      check({tag, ".sel_err"}, 32'(sel_err), 32'(e.err));
      if (out_ready) void'(sb.pop_front());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    cand[0] = 8'h11; cand[1] = 8'h22; cand[2] = 8'h33; cand[3] = 8'h44; cand[4] = 8'h55;
    rst_n = 1'b0;
    drive(1'b0, 0, 0, 1'b0);
    repeat (3) @(negedge clk);
    check("rst.out_valid", 32'(out_valid), 32'h0);
    check("rst.in_ready",  32'(in_ready),  32'h1);
    check("rst.out_a",     32'(out_a),     32'h0);
    check("rst.out_b",     32'(out_b),     32'h0);
    check("rst.sel_err",   32'(sel_err),   32'h0);
    rst_n = 1'b1;

    // Single push: A = cand[2] = 33, B = cand[0] = 11.
    drive(1'b1, 2, 0, 1'b1); tick("single.push");
    if (!BYP) check("single.lat_a", 32'(out_a), 32'h33);
    drive(1'b0, 0, 0, 1'b1); tick("single.out");
    drive(1'b0, 0, 0, 1'b1); tick("single.idle");

    // Fill and backpressure: third push must be refused.
    cand[0] = 8'hA1; drive(1'b1, 0, 0, 1'b0); tick("fill.1");
    cand[0] = 8'hA2; drive(1'b1, 0, 0, 1'b0); tick("fill.2");
    cand[0] = 8'hA3; drive(1'b1, 0, 0, 1'b0); tick("fill.3");
    // Full with out_ready high: push still ignored, no pass-through.
    cand[0] = 8'hA4; drive(1'b1, 0, 0, 1'b1); tick("full.rdy");
    drive(1'b0, 0, 0, 1'b1); tick("drain.1");
    drive(1'b0, 0, 0, 1'b1); tick("drain.2");
    drive(1'b0, 0, 0, 1'b1); tick("drain.3");

    // Streaming six entries with out_ready held high.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NUM_IN; k++) cand[k] = 8'((i + 1) * 16 + k);
      drive(1'b1, i % NUM_IN, (i + 2) % NUM_IN, 1'b1);
      tick("stream");
    end
    drive(1'b0, 0, 0, 1'b1); tick("stream.tail");
    drive(1'b0, 0, 0, 1'b1); tick("stream.idle");

    // Out-of-range selects.
    cand[1] = 8'hA5; cand[4] = 8'h5A;
    drive(1'b1, 7, 1, 1'b1); tick("oor.a");
    drive(1'b1, 4, 1, 1'b1); tick("oor.ok");
    drive(1'b1, 2, 5, 1'b1); tick("oor.b");
    drive(1'b0, 0, 0, 1'b1); tick("oor.tail");
    drive(1'b0, 0, 0, 1'b1); tick("oor.idle");

    // Asynchronous reset with two entries queued.
    cand[2] = 8'hE1; drive(1'b1, 2, 2, 1'b0); tick("ar.q1");
    cand[2] = 8'hE2; drive(1'b1, 2, 2, 1'b0); tick("ar.q2");
    drive(1'b0, 0, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("ar.out_valid", 32'(out_valid), 32'h0);
    check("ar.in_ready",  32'(in_ready),  32'h1);
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cand[3] = 8'h3C;
    drive(1'b1, 3, 4, 1'b0); tick("ar.new");
    drive(1'b0, 0, 0, 1'b1); tick("ar.newout");
    drive(1'b0, 0, 0, 1'b1); tick("ar.idle");

    // Squaring from an empty FIFO (zero latency when bypass is built in).
    cand[3] = 8'hC7;
    drive(1'b1, 3, 3, 1'b1); tick("sq.push");
    drive(1'b0, 0, 0, 1'b1); tick("sq.next");
    drive(1'b0, 0, 0, 1'b1); tick("sq.idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
